// File: rtl/xcvr_chk_pkg.sv
// Shared types, parameter defaults and helpers for the transceiver pattern checker.
package xcvr_chk_pkg;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_COMMA = 2'd1,
        ST_SEED  = 2'd2,
        ST_TRACK = 2'd3
    } chk_state_t;

    localparam int         DEF_DATA_WID    = 32;
    localparam int         DEF_CNT_WID     = 32;
    localparam int         DEF_LOCK_COMMAS = 4;
    localparam int         DEF_MISS_LIMIT  = 8;
    localparam int         DEF_STEP        = 1;
    localparam logic [7:0] DEF_COMMA_BYTE  = 8'hBC;

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < 64; i++) begin
            c = c + {6'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/xcvr_chk_sync.sv
// Two-flop level synchroniser for slow control inputs entering the RX clock domain.
module xcvr_chk_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture; the first stage may go metastable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
        end
    end

    assign dout = sync_r;

endmodule

// File: rtl/xcvr_pattern_chk.sv
// Comma-aligned incrementing-pattern checker for a transceiver RX lane.
// Optional PCS lane reset on bursts of disparity/code errors: define XCVR_CHK_PCS_RST_EN.
module xcvr_pattern_chk
    import xcvr_chk_pkg::*;
#(
    parameter int         DATA_WID    = DEF_DATA_WID,
    parameter int         CNT_WID     = DEF_CNT_WID,
    parameter int         LOCK_COMMAS = DEF_LOCK_COMMAS,
    parameter int         MISS_LIMIT  = DEF_MISS_LIMIT,
    parameter int         STEP        = DEF_STEP,
    parameter logic [7:0] COMMA_BYTE  = DEF_COMMA_BYTE
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  rx_val_i,
    input  logic [DATA_WID-1:0]   data_in_i,
    input  logic [DATA_WID/8-1:0] rx_k_char_i,
    input  logic                  rx_ready_i,
    input  logic [DATA_WID/8-1:0] disp_err_i,
    input  logic [DATA_WID/8-1:0] lcv_err_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    output logic                  lock_o,
    output logic                  error_o,
    output logic [CNT_WID-1:0]    word_err_cnt_o,
    output logic [CNT_WID-1:0]    bit_err_cnt_o,
    output logic [7:0]            relock_cnt_o,
    output logic [1:0]            state_o,
    output logic                  lane_arst_n_o
);

    localparam int KW = DATA_WID / 8;
    localparam int CW = $clog2(LOCK_COMMAS + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);
    localparam logic [KW-1:0]       K_COMMA    = {{(KW-1){1'b0}}, 1'b1};
    localparam logic [DATA_WID-1:0] COMMA_WORD = {{(DATA_WID-8){1'b0}}, COMMA_BYTE};

    logic start_s, clear_s;

    xcvr_chk_sync u_start_sync (.clk(clk_i), .reset_n(reset_n_i), .din(start_i), .dout(start_s));
    xcvr_chk_sync u_clear_sync (.clk(clk_i), .reset_n(reset_n_i), .din(clear_i), .dout(clear_s));

    chk_state_t          state_r;
    logic [CW-1:0]       comma_cnt_r;
    logic [MW-1:0]       miss_r;
    logic [DATA_WID-1:0] exp_r;
    logic                lock_r, err_r;
    logic [CNT_WID-1:0]  word_err_r, bit_err_r;
    logic [7:0]          relock_r;

    logic [DATA_WID-1:0] diff_s;
    logic [6:0]          pc_s;
    logic [CNT_WID:0]    bit_sum_s;
    logic is_comma_s, k_zero_s, trk_s, mis_s, miss_hit_s, seed_s, lock_loss_s;

    assign diff_s      = data_in_i ^ exp_r;
    assign pc_s        = popcount64(64'(diff_s));
    assign bit_sum_s   = {1'b0, bit_err_r} + (CNT_WID+1)'(pc_s);
    assign is_comma_s  = rx_val_i && (rx_k_char_i == K_COMMA) && (data_in_i == COMMA_WORD);
    assign k_zero_s    = (rx_k_char_i == {KW{1'b0}});
    assign trk_s       = rx_val_i && rx_ready_i && (state_r == ST_TRACK);
    assign mis_s       = trk_s && (diff_s != {DATA_WID{1'b0}});
    assign miss_hit_s  = mis_s && ((int'(miss_r) + 32'sd1) >= MISS_LIMIT);
    assign seed_s      = rx_val_i && rx_ready_i && (state_r == ST_SEED) && k_zero_s;
    assign lock_loss_s = lock_r && (!rx_ready_i || miss_hit_s);

    // Alignment FSM, expected-value tracker, error counters and internal error flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= ST_HUNT;
            comma_cnt_r <= {CW{1'b0}};
            miss_r      <= {MW{1'b0}};
            exp_r       <= {DATA_WID{1'b0}};
            lock_r      <= 1'b0;
            err_r       <= 1'b0;
            word_err_r  <= {CNT_WID{1'b0}};
            bit_err_r   <= {CNT_WID{1'b0}};
            relock_r    <= 8'd0;
        end else begin
            if (!rx_ready_i) begin
                state_r     <= ST_HUNT;
                lock_r      <= 1'b0;
                comma_cnt_r <= {CW{1'b0}};
                miss_r      <= {MW{1'b0}};
            end else if (rx_val_i) begin
                case (state_r)
                    ST_HUNT: begin
                        if (is_comma_s) begin
                            comma_cnt_r <= CW'(1'b1);
                            state_r     <= (LOCK_COMMAS <= 1) ? ST_SEED : ST_COMMA;
                        end else begin
                            state_r <= ST_HUNT;
                        end
                    end
                    ST_COMMA: begin
                        if (is_comma_s) begin
                            comma_cnt_r <= comma_cnt_r + CW'(1'b1);
                            if ((int'(comma_cnt_r) + 32'sd1) >= LOCK_COMMAS) begin
                                state_r <= ST_SEED;
                            end else begin
                                state_r <= ST_COMMA;
                            end
                        end else begin
                            // A broken comma run restarts alignment.
                            state_r <= ST_HUNT;
                        end
                    end
                    ST_SEED: begin
                        if (k_zero_s) begin
                            exp_r   <= data_in_i + DATA_WID'(STEP);
                            lock_r  <= 1'b1;
                            miss_r  <= {MW{1'b0}};
                            state_r <= ST_TRACK;
                        end else begin
                            state_r <= ST_SEED;
                        end
                    end
                    ST_TRACK: begin
                        exp_r <= exp_r + DATA_WID'(STEP);
                        if (!mis_s) begin
                            miss_r <= {MW{1'b0}};
                        end else if (miss_hit_s) begin
                            lock_r      <= 1'b0;
                            miss_r      <= {MW{1'b0}};
                            comma_cnt_r <= {CW{1'b0}};
                            state_r     <= ST_HUNT;
                        end else begin
                            miss_r <= miss_r + MW'(1'b1);
                        end
                    end
                    default: state_r <= ST_HUNT;
                endcase
            end else begin
                state_r <= state_r;
            end

            if (clear_s) begin
                word_err_r <= {CNT_WID{1'b0}};
                bit_err_r  <= {CNT_WID{1'b0}};
                relock_r   <= 8'd0;
            end else begin
                if (mis_s) begin
                    word_err_r <= (word_err_r == {CNT_WID{1'b1}}) ? word_err_r
                                                                  : word_err_r + CNT_WID'(1'b1);
                    bit_err_r  <= bit_sum_s[CNT_WID] ? {CNT_WID{1'b1}} : bit_sum_s[CNT_WID-1:0];
                end else begin
                    word_err_r <= word_err_r;
                end
                if (lock_loss_s && (relock_r != 8'hFF)) begin
                    relock_r <= relock_r + 8'd1;
                end else begin
                    relock_r <= relock_r;
                end
            end

            // Clear dominates; otherwise the flag follows the latest comparison or lock state.
            if (clear_s) begin
                err_r <= 1'b0;
            end else if (mis_s) begin
                err_r <= 1'b1;
            end else if (trk_s || seed_s) begin
                err_r <= 1'b0;
            end else if (!lock_r || !rx_ready_i) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Reporting registers: track the internal state only while start is asserted.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_o         <= 1'b0;
            error_o        <= 1'b0;
            word_err_cnt_o <= {CNT_WID{1'b0}};
            bit_err_cnt_o  <= {CNT_WID{1'b0}};
            relock_cnt_o   <= 8'd0;
        end else if (start_s) begin
            lock_o         <= lock_r;
            error_o        <= err_r;
            word_err_cnt_o <= word_err_r;
            bit_err_cnt_o  <= bit_err_r;
            relock_cnt_o   <= relock_r;
        end else begin
            lock_o <= lock_o;
        end
    end

    assign state_o = state_r;

`ifdef XCVR_CHK_PCS_RST_EN
    logic [7:0] win_r;
    logic [2:0] ecnt_r, pcnt_r;
    logic       lane_r, err_word_s;

    assign err_word_s = rx_val_i && rx_ready_i && ((|disp_err_i) || (|lcv_err_i));

    // Windowed errored-word counter driving a fixed four-cycle lane reset pulse.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            win_r  <= 8'd0;
            ecnt_r <= 3'd0;
            pcnt_r <= 3'd0;
            lane_r <= 1'b1;
        end else if (pcnt_r != 3'd0) begin
            pcnt_r <= pcnt_r - 3'd1;
            if (pcnt_r == 3'd1) begin
                lane_r <= 1'b1;
                win_r  <= 8'd0;
                ecnt_r <= 3'd0;
            end else begin
                lane_r <= 1'b0;
            end
        end else if (ecnt_r > 3'd3) begin
            pcnt_r <= 3'd4;
            lane_r <= 1'b0;
        end else begin
            win_r  <= win_r + 8'd1;
            lane_r <= 1'b1;
            if (win_r == 8'hFF) begin
                ecnt_r <= {2'b00, err_word_s};
            end else if (err_word_s) begin
                ecnt_r <= ecnt_r + 3'd1;
            end else begin
                ecnt_r <= ecnt_r;
            end
        end
    end

    assign lane_arst_n_o = lane_r;
`else
    logic unused_pcs_s;
    assign unused_pcs_s  = ^{disp_err_i, lcv_err_i};
    assign lane_arst_n_o = 1'b1;
`endif

endmodule

// File: tb/tb_xcvr_pattern_chk.sv
// Directed self-checking bench for xcvr_pattern_chk (default parameters).
module tb_xcvr_pattern_chk;

    logic        clk = 1'b0;
    logic        reset_n, rx_val, rx_ready, start, clear;
    logic [31:0] data;
    logic [3:0]  rx_k, disp_err, lcv_err;
    logic        lock, error, lane_arst_n;
    logic [31:0] word_err_cnt, bit_err_cnt;
    logic [7:0]  relock_cnt;
    logic [1:0]  state;
    int          checks = 0;
    int          errors = 0;
    int          low_cycles;
    int          exp_low;

    always #5 clk = ~clk;

    xcvr_pattern_chk dut (
        .clk_i(clk), .reset_n_i(reset_n), .rx_val_i(rx_val), .data_in_i(data),
        .rx_k_char_i(rx_k), .rx_ready_i(rx_ready), .disp_err_i(disp_err), .lcv_err_i(lcv_err),
        .start_i(start), .clear_i(clear), .lock_o(lock), .error_o(error),
        .word_err_cnt_o(word_err_cnt), .bit_err_cnt_o(bit_err_cnt), .relock_cnt_o(relock_cnt),
        .state_o(state), .lane_arst_n_o(lane_arst_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [3:0] k, input logic [31:0] d);
        @(negedge clk);
        rx_val = 1'b1; rx_k = k; data = d; disp_err = 4'h0; lcv_err = 4'h0;
    endtask

    task automatic idle();
        @(negedge clk);
        rx_val = 1'b0; rx_k = 4'h0; data = 32'h0; disp_err = 4'h0; lcv_err = 4'h0;
    endtask

    task automatic commas(input int n);
        for (int i = 0; i < n; i++) send(4'h1, 32'h0000_00BC);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b1; clear = 1'b0; rx_val = 1'b0; rx_ready = 1'b1;
        rx_k = 4'h0; data = 32'h0; disp_err = 4'h0; lcv_err = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_lock", 64'(lock), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_word", 64'(word_err_cnt), 64'd0);
        check("rst_bit", 64'(bit_err_cnt), 64'd0);
        check("rst_relock", 64'(relock_cnt), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        check("rst_lane", 64'(lane_arst_n), 64'd1);
        reset_n = 1'b1;
        repeat (4) idle();

        // Comma alignment and seed
        send(4'h1, 32'h0000_00BC); idle();
        check("comma1_state", 64'(state), 64'd1);
        commas(3); idle();
        check("comma4_state", 64'(state), 64'd2);
        send(4'h0, 32'h0000_0010); idle();
        check("seed_lock_n1", 64'(lock), 64'd0);
        idle();
        check("seed_lock_n2", 64'(lock), 64'd1);
        check("seed_error", 64'(error), 64'd0);
        check("seed_state", 64'(state), 64'd3);
        send(4'h0, 32'h11); send(4'h0, 32'h12); send(4'h0, 32'h13); idle(); idle();
        check("track_error", 64'(error), 64'd0);
        check("track_word", 64'(word_err_cnt), 64'd0);
        check("track_bit", 64'(bit_err_cnt), 64'd0);

        // Single corrupted word: 0x14 ^ 0x5
        send(4'h0, 32'h0000_0011); idle(); idle();
        check("inj_word", 64'(word_err_cnt), 64'd1);
        check("inj_bit", 64'(bit_err_cnt), 64'd2);
        check("inj_lock", 64'(lock), 64'd1);
        check("inj_error", 64'(error), 64'd1);
        send(4'h0, 32'h0000_0015); idle(); idle();
        check("recover_error", 64'(error), 64'd0);
        check("recover_word", 64'(word_err_cnt), 64'd1);

        // Eight zero words against expected 0x16..0x1D: 26 bit errors
        for (int i = 0; i < 8; i++) send(4'h0, 32'h0);
        idle(); idle();
        check("loss_lock", 64'(lock), 64'd0);
        check("loss_relock", 64'(relock_cnt), 64'd1);
        check("loss_state", 64'(state), 64'd0);
        check("loss_word", 64'(word_err_cnt), 64'd9);
        check("loss_bit", 64'(bit_err_cnt), 64'd28);
        check("loss_error", 64'(error), 64'd1);

        // Clear while outputs frozen, then release start
        start = 1'b0;
        repeat (3) idle();
        clear = 1'b1; idle(); clear = 1'b0;
        repeat (5) idle();
        check("hold_word", 64'(word_err_cnt), 64'd9);
        check("hold_bit", 64'(bit_err_cnt), 64'd28);
        check("hold_relock", 64'(relock_cnt), 64'd1);
        start = 1'b1;
        repeat (4) idle();
        check("clr_word", 64'(word_err_cnt), 64'd0);
        check("clr_bit", 64'(bit_err_cnt), 64'd0);
        check("clr_relock", 64'(relock_cnt), 64'd0);

        // Re-lock with wrap-around and valid gaps
        commas(4);
        send(4'h0, 32'hFFFF_FFFE); idle();
        send(4'h0, 32'hFFFF_FFFF); idle(); idle();
        send(4'h0, 32'h0000_0000); send(4'h0, 32'h0000_0001); idle(); idle();
        check("wrap_lock", 64'(lock), 64'd1);
        check("wrap_error", 64'(error), 64'd0);
        check("wrap_word", 64'(word_err_cnt), 64'd0);
        check("wrap_state", 64'(state), 64'd3);
        repeat (3) idle();
        send(4'h0, 32'h0000_0002); idle(); idle();
        check("gap_error", 64'(error), 64'd0);
        check("gap_word", 64'(word_err_cnt), 64'd0);

        // RX ready drop counts as a lock loss
        @(negedge clk); rx_ready = 1'b0;
        @(negedge clk); rx_ready = 1'b1;
        idle();
        check("rdy_lock", 64'(lock), 64'd0);
        check("rdy_relock", 64'(relock_cnt), 64'd1);
        check("rdy_state", 64'(state), 64'd0);

        // Reset in TRACK discards the expected value
        commas(4);
        send(4'h0, 32'h0000_0100); idle(); idle();
        check("pre_rst_lock", 64'(lock), 64'd1);
        @(negedge clk); reset_n = 1'b0;
        #1;
        check("arst_lock", 64'(lock), 64'd0);
        check("arst_state", 64'(state), 64'd0);
        check("arst_relock", 64'(relock_cnt), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Four disparity-error words
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_val = 1'b1; rx_k = 4'h0; data = 32'h0; disp_err = 4'h1;
        end
        low_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            idle();
            if (!lane_arst_n) low_cycles++;
        end
`ifdef XCVR_CHK_PCS_RST_EN
        exp_low = 4;
`else
        exp_low = 0;
`endif
        check("lane_low_cycles", 64'(low_cycles), 64'(exp_low));

        send(4'h0, 32'h0000_0101); idle(); idle();
        check("post_rst_state", 64'(state), 64'd0);
        check("post_rst_lock", 64'(lock), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
